fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_unit_instruction_memory.sv | 31 +++
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
// Imported by fetch_unit and instruction_memory.
package fetch_unit_pkg;

    localparam logic [31:0] HALT_INSTR             = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_INSTR              = 32'h0000_0000;
    localparam logic [31:0] PC_INCREMENT           = 32'd4;
    localparam int          DEFAULT_INSTR_MEM_SIZE = 64;

    typedef enum logic [1:0] {
        FETCH_IDLE   = 2'd0,
        FETCH_RUN    = 2'd1,
        FETCH_HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_instruction_memory.sv
// Word-addressed instruction memory: synchronous loader write, combinational read.
// Word indices beyond the array read back as HALT so runaway fetches stop the core.
module instruction_memory
    import fetch_unit_pkg::*;
#(
    parameter  int PC_SIZE        = 32,
    parameter  int BUS_SIZE       = 32,
    parameter  int MEM_SIZE_WORDS = DEFAULT_INSTR_MEM_SIZE,
    localparam int AW             = $clog2(MEM_SIZE_WORDS)
) (
    input  logic                i_clk,
    input  logic                i_wr_en,
    input  logic [AW-1:0]       i_wr_addr,
    input  logic [BUS_SIZE-1:0] i_wr_data,
    input  logic [PC_SIZE-3:0]  i_rd_word,
    output logic [BUS_SIZE-1:0] o_rd_data
);

    logic [BUS_SIZE-1:0] r_mem [MEM_SIZE_WORDS];
    logic                w_in_range;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign w_in_range = (i_rd_word < (PC_SIZE-2)'(MEM_SIZE_WORDS));
    assign o_rd_data  = w_in_range ? r_mem[i_rd_word[AW-1:0]] : BUS_SIZE'(HALT_INSTR);

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC, loader-filled instruction memory and IF/ID register.
// Optional macro FETCH_CYCLE_COUNT_EN adds o_cycle_count (edges spent in RUN).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter  int PC_SIZE        = 32,
    parameter  int BUS_SIZE       = 32,
    parameter  int MEM_SIZE_WORDS = DEFAULT_INSTR_MEM_SIZE,
    localparam int AW             = $clog2(MEM_SIZE_WORDS)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_start,
    input  logic                i_stall,
    input  logic                i_next_pc_src,
    input  logic [PC_SIZE-1:0]  i_next_not_seq_pc,
    input  logic                i_load_en,
    input  logic [AW-1:0]       i_load_addr,
    input  logic [BUS_SIZE-1:0] i_load_data,
    output logic [BUS_SIZE-1:0] o_instruction,
    output logic [PC_SIZE-1:0]  o_next_seq_pc,
    output logic [PC_SIZE-1:0]  o_pc,
    output logic                o_halt,
    output logic                o_mem_full
`ifdef FETCH_CYCLE_COUNT_EN
    ,
    output logic [31:0]         o_cycle_count
`endif
);

    localparam int CW = $clog2(MEM_SIZE_WORDS + 1);

    fetch_state_t        r_state, r_state_next;
    logic [PC_SIZE-1:0]  r_pc, r_pc_next;
    logic [BUS_SIZE-1:0] r_instr, r_instr_next;
    logic [PC_SIZE-1:0]  r_seq_pc, r_seq_pc_next;
    logic [CW-1:0]       r_load_cnt, r_load_cnt_next;

    logic                w_advance;
    logic                w_load_wr;
    logic [PC_SIZE-1:0]  w_pc_plus4;
    logic [BUS_SIZE-1:0] w_fetched;

    assign w_advance  = i_enable && !i_stall;
    assign w_load_wr  = (r_state == FETCH_IDLE) && i_load_en;
    assign w_pc_plus4 = r_pc + PC_SIZE'(PC_INCREMENT);

    instruction_memory #(
        .PC_SIZE        (PC_SIZE),
        .BUS_SIZE       (BUS_SIZE),
        .MEM_SIZE_WORDS (MEM_SIZE_WORDS)
    ) u_imem (
        .i_clk     (i_clk),
        .i_wr_en   (w_load_wr),
        .i_wr_addr (i_load_addr),
        .i_wr_data (i_load_data),
        .i_rd_word (r_pc[PC_SIZE-1:2]),
        .o_rd_data (w_fetched)
    );

    always_comb begin
        r_state_next    = r_state;
        r_pc_next       = r_pc;
        r_instr_next    = r_instr;
        r_seq_pc_next   = r_seq_pc;
        r_load_cnt_next = r_load_cnt;
        case (r_state)
            FETCH_IDLE: begin
                if (i_load_en && (r_load_cnt != CW'(MEM_SIZE_WORDS))) begin
                    r_load_cnt_next = r_load_cnt + 1'b1;
                end
                if (i_start) begin
                    r_state_next = FETCH_RUN;
                end
            end
            FETCH_RUN: begin
                if (w_advance) begin
                    r_instr_next  = w_fetched;
                    r_seq_pc_next = w_pc_plus4;
                    r_pc_next     = i_next_pc_src ? i_next_not_seq_pc : w_pc_plus4;
                    if (w_fetched == BUS_SIZE'(HALT_INSTR)) begin
                        r_state_next = FETCH_HALTED;
                    end
                end
            end
            FETCH_HALTED: begin
                // Keep feeding bubbles so the downstream stages drain.
                if (w_advance) begin
                    r_instr_next = BUS_SIZE'(NOP_INSTR);
                end
            end
            default: r_state_next = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= FETCH_IDLE;
            r_pc       <= '0;
            r_instr    <= BUS_SIZE'(NOP_INSTR);
            r_seq_pc   <= '0;
            r_load_cnt <= '0;
        end else begin
            r_state    <= r_state_next;
            r_pc       <= r_pc_next;
            r_instr    <= r_instr_next;
            r_seq_pc   <= r_seq_pc_next;
            r_load_cnt <= r_load_cnt_next;
        end
    end

`ifdef FETCH_CYCLE_COUNT_EN
    logic [31:0] r_cycle_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cycle_count <= '0;
        end else if (r_state == FETCH_RUN) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign o_cycle_count = r_cycle_count;
`endif

    assign o_instruction = r_instr;
    assign o_next_seq_pc = r_seq_pc;
    assign o_pc          = r_pc;
    assign o_halt        = (r_state == FETCH_HALTED);
    assign o_mem_full    = (r_load_cnt == CW'(MEM_SIZE_WORDS));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// compared against a behavioural model of the fetch rules.
module tb_fetch_unit;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_start = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_next_pc_src = 1'b0;
    logic [31:0] i_next_not_seq_pc = '0;
    logic        i_load_en = 1'b0;
    logic [5:0]  i_load_addr = '0;
    logic [31:0] i_load_data = '0;
    logic [31:0] o_instruction, o_next_seq_pc, o_pc;
    logic        o_halt, o_mem_full;
`ifdef FETCH_CYCLE_COUNT_EN
    logic [31:0] o_cycle_count;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.PC_SIZE(32), .BUS_SIZE(32), .MEM_SIZE_WORDS(64)) dut (
        .i_clk             (clk),
        .i_reset           (i_reset),
        .i_enable          (i_enable),
        .i_start           (i_start),
        .i_stall           (i_stall),
        .i_next_pc_src     (i_next_pc_src),
        .i_next_not_seq_pc (i_next_not_seq_pc),
        .i_load_en         (i_load_en),
        .i_load_addr       (i_load_addr),
        .i_load_data       (i_load_data),
        .o_instruction     (o_instruction),
        .o_next_seq_pc     (o_next_seq_pc),
        .o_pc              (o_pc),
        .o_halt            (o_halt),
        .o_mem_full        (o_mem_full)
`ifdef FETCH_CYCLE_COUNT_EN
        ,
        .o_cycle_count     (o_cycle_count)
`endif
    );

    // Behavioural model: mode 0 = idle/loading, 1 = fetching, 2 = halted.
    logic [31:0] m_mem [64];
    logic [31:0] m_pc, m_instr, m_seq, m_cyc;
    int          m_mode, m_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [31:0] m_fetch(input logic [31:0] pc);
        if ((pc >> 2) >= 32'd64) return HALT;
        return m_mem[pc[7:2]];
    endfunction

    task automatic model_edge();
        logic [31:0] f;
        if (m_mode == 0) begin
            if (i_load_en) begin
                m_mem[i_load_addr] = i_load_data;
                if (m_cnt < 64) m_cnt++;
            end
            if (i_start) m_mode = 1;
        end else if (m_mode == 1) begin
            m_cyc = m_cyc + 32'd1;
            if (i_enable && !i_stall) begin
                f       = m_fetch(m_pc);
                m_instr = f;
                m_seq   = m_pc + 32'd4;
                m_pc    = i_next_pc_src ? i_next_not_seq_pc : m_pc + 32'd4;
                if (f == HALT) m_mode = 2;
            end
        end else begin
            if (i_enable && !i_stall) m_instr = 32'd0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_enable = 0; i_start = 0; i_stall = 0; i_next_pc_src = 0;
        i_next_not_seq_pc = '0; i_load_en = 0; i_load_addr = '0; i_load_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_reset = 1;
        m_pc = 0; m_instr = 0; m_seq = 0; m_mode = 0; m_cnt = 0; m_cyc = 0;
        @(posedge clk);
        #1;
        i_reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (o_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", o_pc); end
        n_checks++; if (o_instruction !== 32'd0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", o_instruction); end
        n_checks++; if (o_next_seq_pc !== 32'd0) begin n_fail++; $display("FAIL reset_seq got=%h exp=0", o_next_seq_pc); end
        n_checks++; if (o_halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt got=%b exp=0", o_halt); end
        n_checks++; if (o_mem_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", o_mem_full); end
        $display("txn reset pc=%h instr=%h", o_pc, o_instruction);
    endtask

    task automatic test_capacity();
        for (int i = 0; i < 64; i++) begin
            i_load_en = 1; i_load_addr = 6'(i); i_load_data = $urandom & 32'h7FFF_FFFF;
            tick();
            if (i == 62) begin
                n_checks++; if (o_mem_full !== 1'b0) begin n_fail++; $display("FAIL full_early got=%b exp=0", o_mem_full); end
            end
        end
        n_checks++; if (o_mem_full !== 1'b1) begin n_fail++; $display("FAIL full_64 got=%b exp=1", o_mem_full); end
        n_checks++; if (o_pc !== 32'd0 || o_instruction !== 32'd0) begin n_fail++; $display("FAIL idle_hold pc=%h instr=%h exp=0/0", o_pc, o_instruction); end
        i_load_addr = 6'd5; i_load_data = $urandom & 32'h7FFF_FFFF;
        tick();
        i_load_en = 0;
        n_checks++; if (o_mem_full !== 1'b1) begin n_fail++; $display("FAIL full_sat got=%b exp=1", o_mem_full); end
        $display("txn capacity full=%b", o_mem_full);
    endtask

    task automatic test_load();
        logic [31:0] w [3];
        for (int i = 0; i < 3; i++) begin
            w[i] = $urandom & 32'h7FFF_FFFF;
            i_load_en = 1; i_load_addr = 6'(i); i_load_data = w[i];
            i_start = (i == 2);
            tick();
        end
        i_load_en = 0; i_start = 0; i_enable = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (o_instruction !== w[k]) begin n_fail++; $display("FAIL load_instr%0d got=%h exp=%h", k, o_instruction, w[k]); end
            n_checks++; if (o_next_seq_pc !== 32'(4 * (k + 1))) begin n_fail++; $display("FAIL load_seq%0d got=%h exp=%h", k, o_next_seq_pc, 4 * (k + 1)); end
            $display("txn load k=%0d instr=%h seq=%h", k, o_instruction, o_next_seq_pc);
        end
    endtask

    task automatic test_branch();
        do_reset();
        i_start = 1; tick(); i_start = 0;
        i_enable = 1; tick(); tick();
        i_next_pc_src = 1; i_next_not_seq_pc = 32'h20;
        tick();
        n_checks++; if (o_instruction !== m_mem[2]) begin n_fail++; $display("FAIL branch_slot got=%h exp=%h", o_instruction, m_mem[2]); end
        n_checks++; if (o_pc !== 32'h20) begin n_fail++; $display("FAIL branch_pc got=%h exp=20", o_pc); end
        i_next_pc_src = 0;
        tick();
        n_checks++; if (o_instruction !== m_mem[8] || o_next_seq_pc !== 32'h24) begin
            n_fail++; $display("FAIL branch_target got=%h/%h exp=%h/24", o_instruction, o_next_seq_pc, m_mem[8]);
        end
        $display("txn branch pc=%h instr=%h", o_pc, o_instruction);
    endtask

    task automatic test_stall();
        do_reset();
        i_start = 1; tick(); i_start = 0;
        i_enable = 1; tick();
        i_stall = 1; i_next_pc_src = 1; i_next_not_seq_pc = 32'h40;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++; if (o_pc !== 32'd4 || o_instruction !== m_mem[0] || o_next_seq_pc !== 32'd4) begin
                n_fail++; $display("FAIL stall_hold%0d pc=%h instr=%h seq=%h exp=4/%h/4", c, o_pc, o_instruction, o_next_seq_pc, m_mem[0]);
            end
        end
        i_stall = 0;
        tick();
        n_checks++; if (o_pc !== 32'h40 || o_instruction !== m_mem[1]) begin
            n_fail++; $display("FAIL stall_release pc=%h instr=%h exp=40/%h", o_pc, o_instruction, m_mem[1]);
        end
        $display("txn stall pc=%h instr=%h", o_pc, o_instruction);
    endtask

    task automatic test_halt();
        do_reset();
        i_load_en = 1; i_load_addr = 6'd3; i_load_data = HALT; tick();
        i_load_en = 0; i_start = 1; tick(); i_start = 0;
        i_enable = 1;
        tick(); tick(); tick();
        n_checks++; if (o_halt !== 1'b0) begin n_fail++; $display("FAIL halt_early got=%b exp=0", o_halt); end
        tick();
        n_checks++; if (o_halt !== 1'b1 || o_instruction !== HALT || o_pc !== 32'h10) begin
            n_fail++; $display("FAIL halt_latch halt=%b instr=%h pc=%h exp=1/ffffffff/10", o_halt, o_instruction, o_pc);
        end
        i_load_en = 1; i_load_addr = 6'd0; i_load_data = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (o_instruction !== 32'd0 || o_pc !== 32'h10 || o_next_seq_pc !== 32'h10 || o_halt !== 1'b1) begin
                n_fail++; $display("FAIL halt_drain%0d instr=%h pc=%h seq=%h halt=%b exp=0/10/10/1", c, o_instruction, o_pc, o_next_seq_pc, o_halt);
            end
        end
        i_load_en = 0;
        $display("txn halt pc=%h halt=%b", o_pc, o_halt);
    endtask

    task automatic test_async_reset();
        do_reset();
        i_start = 1; tick(); i_start = 0;
        i_enable = 1; tick(); tick();
        #2;
        i_reset = 1;
        #1;
        n_checks++; if (o_pc !== 32'd0 || o_halt !== 1'b0 || o_instruction !== 32'd0) begin
            n_fail++; $display("FAIL async_reset pc=%h halt=%b instr=%h exp=0/0/0", o_pc, o_halt, o_instruction);
        end
        $display("txn async_reset pc=%h", o_pc);
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 64; i++) begin
            i_load_en = 1; i_load_addr = 6'(i);
            i_load_data = ($urandom_range(0, 9) == 0) ? HALT : $urandom;
            tick();
        end
        idle_inputs();
        for (int n = 0; n < 300; n++) begin
            if (m_mode == 2 && $urandom_range(0, 5) == 0) do_reset();
            i_start           = ($urandom_range(0, 3) == 0);
            i_load_en         = ($urandom_range(0, 1) == 0);
            i_load_addr       = 6'($urandom_range(0, 63));
            i_load_data       = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
            i_enable          = ($urandom_range(0, 3) != 0);
            i_stall           = ($urandom_range(0, 3) == 0);
            i_next_pc_src     = ($urandom_range(0, 4) == 0);
            i_next_not_seq_pc = ($urandom_range(0, 72) << 2) | $urandom_range(0, 3);
            tick();
            n_checks++; if (o_pc !== m_pc) begin n_fail++; $display("FAIL rand_pc n=%0d got=%h exp=%h", n, o_pc, m_pc); end
            n_checks++; if (o_instruction !== m_instr) begin n_fail++; $display("FAIL rand_instr n=%0d got=%h exp=%h", n, o_instruction, m_instr); end
            n_checks++; if (o_next_seq_pc !== m_seq) begin n_fail++; $display("FAIL rand_seq n=%0d got=%h exp=%h", n, o_next_seq_pc, m_seq); end
            n_checks++; if (o_halt !== (m_mode == 2)) begin n_fail++; $display("FAIL rand_halt n=%0d got=%b exp=%b", n, o_halt, m_mode == 2); end
            n_checks++; if (o_mem_full !== (m_cnt == 64)) begin n_fail++; $display("FAIL rand_full n=%0d got=%b exp=%b", n, o_mem_full, m_cnt == 64); end
`ifdef FETCH_CYCLE_COUNT_EN
            n_checks++; if (o_cycle_count !== m_cyc) begin n_fail++; $display("FAIL rand_cyc n=%0d got=%0d exp=%0d", n, o_cycle_count, m_cyc); end
`endif
            $display("txn rand n=%0d pc=%h instr=%h seq=%h halt=%b", n, o_pc, o_instruction, o_next_seq_pc, o_halt);
        end
    endtask

    initial begin
        test_reset();
        test_capacity();
        test_load();
        test_branch();
        test_stall();
        test_halt();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
